// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), counter width and sync polarity.
// Also holds the window-compare helper used for the sync pulses.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam logic SYNC_ACTIVE = 1'b0;

  // Inclusive window test on unsigned counter values.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with enable; wrap flags the enabled step from MOD-1 back to 0.
module mod_counter
  import vga_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: wrap at the terminal value, otherwise step when enabled.
  always_comb begin
    value_d = value_q;
    wrap    = en && (value_q == LAST);
    if (wrap) begin
      value_d = '0;
    end else if (en) begin
      value_d = value_q + 11'd1;
    end else begin
      value_d = value_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-clock divider, horizontal/vertical scan counters and
// registered sync / video_on / frame_start outputs aligned with the counters.
module vga_sync
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int CLK_DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] pixel_col,
  output logic [CNT_W-1:0] pixel_row,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_tick,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_value;
  logic             div_wrap;
  logic [CNT_W-1:0] col;
  logic             h_wrap;
  logic [CNT_W-1:0] row;
  logic             v_wrap;

  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;

  logic hsync_d, hsync_q;
  logic vsync_d, vsync_q;
  logic video_on_d, video_on_q;
  logic frame_start_d, frame_start_q;
  logic started_q;

  mod_counter #(.MOD(CLK_DIV)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .value (div_value),
    .wrap  (div_wrap)
  );

  mod_counter #(.MOD(H_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_wrap),
    .value (col),
    .wrap  (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .value (row),
    .wrap  (v_wrap)
  );

  assign pix_tick = (div_value == DIV_LAST);

  // Decode outputs from the counter values the next edge will load, so they switch with them.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (h_wrap) begin
      col_nxt = '0;
    end else if (pix_tick) begin
      col_nxt = col + 11'd1;
    end else begin
      col_nxt = col;
    end
    if (v_wrap) begin
      row_nxt = '0;
    end else if (h_wrap) begin
      row_nxt = row + 11'd1;
    end else begin
      row_nxt = row;
    end
    hsync_d       = in_window(col_nxt, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d       = in_window(row_nxt, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    video_on_d    = (col_nxt < H_VIS) && (row_nxt < V_VIS);
    // First edge out of reset starts a frame just like a vertical wrap.
    frame_start_d = !started_q || v_wrap;
  end

  // Output registers; reset forces sync inactive and aborts the frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      started_q     <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      started_q     <= 1'b1;
    end
  end

  assign pixel_col   = col;
  assign pixel_row   = row;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default 640x480 timing with CLK_DIV=2, plus a tiny
// 20x10 raster with CLK_DIV=1 for full-frame, vsync and mid-frame reset checks.
module tb_vga_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_n2;

  logic [10:0] col1, row1;
  logic        von1, hs1, vs1, pt1, fs1;
  logic [10:0] col2, row2;
  logic        von2, hs2, vs2, pt2, fs2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vga_sync dut1 (
    .clk(clk), .rst_n(rst_n), .pixel_col(col1), .pixel_row(row1), .video_on(von1),
    .hsync(hs1), .vsync(vs1), .pix_tick(pt1), .frame_start(fs1)
  );

  vga_sync #(
    .H_VISIBLE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VISIBLE(6),  .V_FP(1), .V_SYNC(1), .V_BP(2),
    .CLK_DIV(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n2), .pixel_col(col2), .pixel_row(row2), .video_on(von2),
    .hsync(hs2), .vsync(vs2), .pix_tick(pt2), .frame_start(fs2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_low, von_cnt, bad, first_hs_col, vs_low, first_vs_col, fs_cnt;
    int exp_col, exp_row;

    rst_n  = 1'b0;
    rst_n2 = 1'b0;
    repeat (3) tick();

    check("rst_col",   col1, 0);
    check("rst_row",   row1, 0);
    check("rst_hsync", hs1,  1);
    check("rst_vsync", vs1,  1);
    check("rst_von",   von1, 0);
    check("rst_fs",    fs1,  0);
    check("rst_tick",  pt1,  0);

    // One full line at CLK_DIV=2: edge n after release shows col n/2.
    rst_n = 1'b1;
    hs_low = 0; von_cnt = 0; bad = 0; first_hs_col = -1;
    for (int n = 1; n <= 1600; n++) begin
      tick();
      if (n == 1) begin
        check("rel_fs",   fs1,  1);
        check("rel_von",  von1, 1);
        check("rel_col",  col1, 0);
        check("rel_tick", pt1,  1);
      end
      if (n == 2) begin
        check("col1_after2", col1, 1);
        check("fs_one_clk",  fs1,  0);
      end
      exp_col = (n / 2) % 800;
      exp_row = n / 1600;
      if (col1 !== 11'(exp_col) || row1 !== 11'(exp_row)) bad++;
      if (hs1 === 1'b0) begin
        if (first_hs_col < 0) first_hs_col = int'(col1);
        hs_low++;
      end
      if (hs1 !== ((exp_col >= 656 && exp_col <= 751) ? 1'b0 : 1'b1)) bad++;
      if (von1 === 1'b1) von_cnt++;
      if (von1 !== ((exp_col < 640) ? 1'b1 : 1'b0)) bad++;
      if (vs1 !== 1'b1) bad++;
    end
    check("line_wrap_col", col1, 0);
    check("line_wrap_row", row1, 1);
    check("line_hs_low",   hs_low, 192);
    check("line_hs_first", first_hs_col, 656);
    check("line_von_cnt",  von_cnt, 1280);
    check("line_invariants", bad, 0);

    // Advance to col 700 inside hsync, then reset mid-line.
    repeat (1400) tick();
    check("pre_rst_col",   col1, 700);
    check("pre_rst_hsync", hs1,  0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_col",   col1, 0);
    check("mid_rst_row",   row1, 0);
    check("mid_rst_hsync", hs1,  1);
    check("mid_rst_von",   von1, 0);
    rst_n = 1'b1;
    tick();
    check("mid_rel_fs",  fs1,  1);
    check("mid_rel_pos", {row1, col1}, 0);

    // Tiny raster, CLK_DIV=1: edge n after release shows col n%20, row (n/20)%10.
    rst_n2 = 1'b1;
    vs_low = 0; hs_low = 0; von_cnt = 0; bad = 0; first_vs_col = -1; fs_cnt = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) begin
        check("s_rel_fs",  fs2,  1);
        check("s_rel_col", col2, 1);
      end
      if (n == 199) begin
        check("s_last_pos", {row2, col2}, {11'd9, 11'd19});
        check("s_last_fs",  fs2, 0);
      end
      if (pt2 !== 1'b1) bad++;
      exp_col = n % 20;
      exp_row = (n / 20) % 10;
      if (col2 !== 11'(exp_col) || row2 !== 11'(exp_row)) bad++;
      if (vs2 === 1'b0) begin
        if (first_vs_col < 0) first_vs_col = int'(col2);
        vs_low++;
      end
      if (vs2 !== ((exp_row == 7) ? 1'b0 : 1'b1)) bad++;
      if (hs2 === 1'b0) hs_low++;
      if (von2 === 1'b1) von_cnt++;
      if (fs2 === 1'b1) fs_cnt++;
    end
    check("s_wrap_pos",  {row2, col2}, 0);
    check("s_wrap_fs",   fs2, 1);
    check("s_fs_cnt",    fs_cnt, 2);
    check("s_vs_low",    vs_low, 20);
    check("s_vs_first",  first_vs_col, 0);
    check("s_hs_low",    hs_low, 30);
    check("s_von_cnt",   von_cnt, 72);
    check("s_invariants", bad, 0);

    // Reset inside both sync pulses (row 7, col 15).
    repeat (155) tick();
    check("s_pre_pos",   {row2, col2}, {11'd7, 11'd15});
    check("s_pre_sync",  {hs2, vs2}, 2'b00);
    rst_n2 = 1'b0;
    tick();
    check("s_rst_pos",   {row2, col2}, 0);
    check("s_rst_sync",  {hs2, vs2}, 2'b11);
    check("s_rst_vonfs", {von2, fs2}, 2'b00);
    rst_n2 = 1'b1;
    tick();
    check("s_rel2_fs",  fs2,  1);
    check("s_rel2_von", von2, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
